// File: rtl/rect_draw_arbiter_pkg.sv
// Shared definitions for the rectangle draw arbiter: screen limits, requester
// indices, field widths and the FSM state encoding.
package rect_draw_arbiter_pkg;

    localparam int NUM_REQ  = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int REQ_LOAD = 0;
    localparam int REQ_BALL = 1;
    localparam int REQ_PLAT = 2;

    localparam int COORD_W  = 10;
    localparam int SIZE_W   = 6;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic onScreen(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return (x < COORD_W'(SCREEN_W)) && (y < COORD_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/rect_draw_arbiter_if.sv
// Request/grant bundle between the requesting FSMs and the arbiter, plus the
// pixel port the arbiter drives towards the VGA adapter.
interface rect_draw_arbiter_if
    import rect_draw_arbiter_pkg::*;
#(
    parameter int NREQ = NUM_REQ
);
    logic [NREQ-1:0]          req;
    logic [NREQ*COORD_W-1:0]  x_in;
    logic [NREQ*COORD_W-1:0]  y_in;
    logic [NREQ*SIZE_W-1:0]   w_in;
    logic [NREQ*SIZE_W-1:0]   h_in;
    logic [NREQ*COLOUR_W-1:0] colour_in;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          done;
    logic                     busy;
    logic [COORD_W-1:0]       vga_x;
    logic [COORD_W-1:0]       vga_y;
    logic [COLOUR_W-1:0]      vga_colour;
    logic                     plot;

    modport master (
        output req, x_in, y_in, w_in, h_in, colour_in,
        input  gnt, done, busy, vga_x, vga_y, vga_colour, plot
    );

    modport slave (
        input  req, x_in, y_in, w_in, h_in, colour_in,
        output gnt, done, busy, vga_x, vga_y, vga_colour, plot
    );

endinterface

// File: rtl/rect_draw_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after i_last
// (wrapping, i_last itself checked last) wins.
module rect_draw_arbiter_rr_pick #(
    parameter int N    = 3,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [N-1:0]    o_grant,
    output logic            o_valid
);
    localparam int SUMW = IDXW + 1;

    logic [SUMW-1:0] w_sum;
    logic [IDXW-1:0] w_idx;
    logic            w_found;

    // i_last + k never exceeds 2N-1, so a single subtraction gives the modulo
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = SUMW'(i_last) + SUMW'(k);
            if (w_sum >= SUMW'(N)) begin
                w_sum = w_sum - SUMW'(N);
            end
            w_idx = w_sum[IDXW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/rect_draw_arbiter.sv
// Shares the VGA plot port between NREQ rectangle requesters: grants
// round-robin, then sweeps the latched rectangle one pixel per clock.
module rect_draw_arbiter
    import rect_draw_arbiter_pkg::*;
#(
    parameter int NREQ = NUM_REQ
) (
    input  logic                clk,
    input  logic                reset,
    rect_draw_arbiter_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               r_state;
    logic [IDXW-1:0]      r_rrLast;
    logic [IDXW-1:0]      r_owner;
    logic [NREQ-1:0]      r_ownerOh;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic                 r_busy;
    logic                 r_plot;
    logic [COORD_W-1:0]   r_vgaX;
    logic [COORD_W-1:0]   r_vgaY;
    logic [COLOUR_W-1:0]  r_vgaColour;
    logic [COORD_W-1:0]   r_x0;
    logic [COORD_W-1:0]   r_y0;
    logic [SIZE_W-1:0]    r_w;
    logic [SIZE_W-1:0]    r_h;
    logic [SIZE_W-1:0]    r_cx;
    logic [SIZE_W-1:0]    r_cy;
    logic                 r_zero;

    logic [NREQ-1:0]      w_win;
    logic                 w_valid;
    logic [IDXW-1:0]      w_winIdx;
    logic [COORD_W-1:0]   w_selX;
    logic [COORD_W-1:0]   w_selY;
    logic [SIZE_W-1:0]    w_selW;
    logic [SIZE_W-1:0]    w_selH;
    logic [COLOUR_W-1:0]  w_selColour;
    logic                 w_endOfRow;
    logic                 w_lastPixel;
    logic [SIZE_W-1:0]    w_nextCx;
    logic [SIZE_W-1:0]    w_nextCy;
    logic [COORD_W-1:0]   w_pixX;
    logic [COORD_W-1:0]   w_pixY;

    rect_draw_arbiter_rr_pick #(.N(NREQ), .IDXW(IDXW)) u_rrPick (
        .i_req   (bus.req),
        .i_last  (r_rrLast),
        .o_grant (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_winIdx    = '0;
        w_selX      = '0;
        w_selY      = '0;
        w_selW      = '0;
        w_selH      = '0;
        w_selColour = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_winIdx    = IDXW'(i);
                w_selX      = bus.x_in[COORD_W*i +: COORD_W];
                w_selY      = bus.y_in[COORD_W*i +: COORD_W];
                w_selW      = bus.w_in[SIZE_W*i +: SIZE_W];
                w_selH      = bus.h_in[SIZE_W*i +: SIZE_W];
                w_selColour = bus.colour_in[COLOUR_W*i +: COLOUR_W];
            end
        end
    end

    // Raster step from the pixel currently on the port to the next one
    always_comb begin
        w_endOfRow  = (r_cx == r_w - 6'd1);
        w_lastPixel = r_zero || (w_endOfRow && (r_cy == r_h - 6'd1));
        w_nextCx    = w_endOfRow ? '0 : r_cx + 6'd1;
        w_nextCy    = w_endOfRow ? r_cy + 6'd1 : r_cy;
        w_pixX      = r_x0 + COORD_W'(w_nextCx);
        w_pixY      = r_y0 + COORD_W'(w_nextCy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rrLast    <= IDXW'(NREQ - 1);
            r_owner     <= '0;
            r_ownerOh   <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_plot      <= 1'b0;
            r_vgaX      <= '0;
            r_vgaY      <= '0;
            r_vgaColour <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                // The first pixel is launched together with the grant
                IDLE: begin
                    if (w_valid) begin
                        r_x0        <= w_selX;
                        r_y0        <= w_selY;
                        r_w         <= w_selW;
                        r_h         <= w_selH;
                        r_zero      <= (w_selW == '0) || (w_selH == '0);
                        r_owner     <= w_winIdx;
                        r_ownerOh   <= w_win;
                        r_cx        <= '0;
                        r_cy        <= '0;
                        r_gnt       <= w_win;
                        r_busy      <= 1'b1;
                        r_vgaX      <= w_selX;
                        r_vgaY      <= w_selY;
                        r_vgaColour <= w_selColour;
                        r_plot      <= (w_selW != '0) && (w_selH != '0)
                                       && onScreen(w_selX, w_selY);
                        r_state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (w_lastPixel) begin
                        r_plot  <= 1'b0;
                        r_done  <= r_ownerOh;
                        r_state <= DONE;
                    end else begin
                        r_cx   <= w_nextCx;
                        r_cy   <= w_nextCy;
                        r_vgaX <= w_pixX;
                        r_vgaY <= w_pixY;
                        r_plot <= onScreen(w_pixX, w_pixY);
                    end
                end
                DONE: begin
                    r_rrLast <= r_owner;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;
    assign bus.plot       = r_plot;
    assign bus.vga_x      = r_vgaX;
    assign bus.vga_y      = r_vgaY;
    assign bus.vga_colour = r_vgaColour;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Self-checking bench for rect_draw_arbiter: directed scenarios plus random
// traffic checked against a rectangle-list / round-robin reference model.
module tb_rect_draw_arbiter;
    import rect_draw_arbiter_pkg::*;

    localparam int NR = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rect_draw_arbiter_if #(.NREQ(NR)) busIf ();

    rect_draw_arbiter #(.NREQ(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    int vectors     = 0;
    int miscompares = 0;
    int modelRrLast = NR - 1;
    int fx[NR], fy[NR], fw[NR], fh[NR], fc[NR];
    logic [NR-1:0] reqMask = '0;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveInputs();
        busIf.req = reqMask;
        for (int i = 0; i < NR; i++) begin
            busIf.x_in[10*i +: 10]     = 10'(fx[i]);
            busIf.y_in[10*i +: 10]     = 10'(fy[i]);
            busIf.w_in[6*i +: 6]       = 6'(fw[i]);
            busIf.h_in[6*i +: 6]       = 6'(fh[i]);
            busIf.colour_in[3*i +: 3]  = 3'(fc[i]);
        end
    endtask

    task automatic setRect(input int i, input int x, input int y, input int w, input int h, input int c);
        fx[i] = x; fy[i] = y; fw[i] = w; fh[i] = h; fc[i] = c;
    endtask

    task automatic randomRect(input int i);
        fx[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 170));
        fy[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 130));
        fw[i] = $urandom_range(0, 7);
        fh[i] = $urandom_range(0, 7);
        fc[i] = $urandom_range(0, 7);
    endtask

    function automatic int pickWinner(input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++) begin
            int idx = (modelRrLast + k) % NR;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    // Entered at the negedge of an IDLE cycle with the request already driven;
    // returns at the negedge of the IDLE cycle following done.
    task automatic serveRect(input int owner, input bit dropOwn, input logic [NR-1:0] midRaise);
        int x0 = fx[owner];
        int y0 = fy[owner];
        int w  = fw[owner];
        int h  = fh[owner];
        int c  = fc[owner];
        int n  = (w == 0 || h == 0) ? 1 : w * h;
        int px = x0;
        int py = y0;
        bit pl;
        logic [NR-1:0] oh;
        logic [23:0] expPix, gotPix;
        logic [2*NR:0] expCtl, gotCtl;
        logic [2*NR+1:0] expIdle, gotIdle;
        oh = NR'(1) << owner;
        @(negedge clk);
        for (int p = 0; p < n; p++) begin
            if (w == 0 || h == 0) begin
                px = x0; py = y0; pl = 1'b0;
            end else begin
                px = (x0 + p % w) % 1024;
                py = (y0 + p / w) % 1024;
                pl = (px < SCREEN_W) && (py < SCREEN_H);
            end
            expPix = {pl, 10'(px), 10'(py), 3'(c)};
            gotPix = {busIf.plot, busIf.vga_x, busIf.vga_y, busIf.vga_colour};
            vectors++;
            if (gotPix !== expPix) begin
                miscompares++;
                $display("[TB] FAIL pixel[%0d] req%0d {plot,x,y,col}: got %h expected %h", p, owner, gotPix, expPix);
            end
            expCtl = {(p == 0) ? oh : {NR{1'b0}}, {NR{1'b0}}, 1'b1};
            gotCtl = {busIf.gnt, busIf.done, busIf.busy};
            vectors++;
            if (gotCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL draw_ctl[%0d] req%0d {gnt,done,busy}: got %b expected %b", p, owner, gotCtl, expCtl);
            end
            if (p == 0 && dropOwn) begin
                reqMask[owner] = 1'b0;
                randomRect(owner);
                driveInputs();
            end
            if (midRaise != '0 && p == n / 2) begin
                reqMask = reqMask | midRaise;
                driveInputs();
            end
            @(negedge clk);
        end
        expPix = {1'b0, 10'(px), 10'(py), 3'(c)};
        gotPix = {busIf.plot, busIf.vga_x, busIf.vga_y, busIf.vga_colour};
        expCtl = {{NR{1'b0}}, oh, 1'b1};
        gotCtl = {busIf.gnt, busIf.done, busIf.busy};
        vectors++;
        if ({gotCtl, gotPix} !== {expCtl, expPix}) begin
            miscompares++;
            $display("[TB] FAIL done req%0d {gnt,done,busy,plot,x,y,col}: got %h expected %h", owner, {gotCtl, gotPix}, {expCtl, expPix});
        end
        modelRrLast = owner;
        @(negedge clk);
        expIdle = '0;
        gotIdle = {busIf.gnt, busIf.done, busIf.busy, busIf.plot};
        vectors++;
        if (gotIdle !== expIdle) begin
            miscompares++;
            $display("[TB] FAIL idle_after req%0d {gnt,done,busy,plot}: got %b expected %b", owner, gotIdle, expIdle);
        end
    endtask

    task automatic test_reset();
        logic [30:0] got;
        reset   = 1'b1;
        reqMask = '0;
        driveInputs();
        repeat (2) @(negedge clk);
        got = {busIf.gnt, busIf.done, busIf.busy, busIf.plot, busIf.vga_x, busIf.vga_y, busIf.vga_colour};
        vectors++;
        if (got !== 31'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got, 31'd0);
        end
        reset       = 1'b0;
        modelRrLast = NR - 1;
        @(negedge clk);
        got = {busIf.gnt, busIf.done, busIf.busy, busIf.plot, busIf.vga_x, busIf.vga_y, busIf.vga_colour};
        vectors++;
        if (got !== 31'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_no_req: got %h expected %h", got, 31'd0);
        end
    endtask

    task automatic test_singleRect();
        test_reset();
        setRect(REQ_LOAD, 8, 4, 4, 2, 3'b100);
        reqMask = 3'b001;
        driveInputs();
        serveRect(REQ_LOAD, 1'b1, '0);
    endtask

    task automatic test_roundRobin();
        int order[4] = '{0, 1, 0, 1};
        test_reset();
        setRect(0, $urandom_range(0, 159), $urandom_range(0, 119), 1, 1, $urandom_range(0, 7));
        setRect(1, $urandom_range(0, 159), $urandom_range(0, 119), 1, 1, $urandom_range(0, 7));
        reqMask = 3'b011;
        driveInputs();
        for (int i = 0; i < 4; i++) begin
            serveRect(order[i], 1'b0, '0);
        end
        reqMask = '0;
        driveInputs();
    endtask

    task automatic test_simultaneous();
        test_reset();
        setRect(REQ_LOAD, $urandom_range(0, 150), $urandom_range(0, 110), 2, 2, 1);
        setRect(REQ_PLAT, $urandom_range(0, 150), $urandom_range(0, 110), 3, 2, 6);
        reqMask = 3'b101;
        driveInputs();
        serveRect(REQ_LOAD, 1'b1, '0);
        setRect(REQ_LOAD, $urandom_range(0, 150), $urandom_range(0, 110), 2, 1, 3);
        serveRect(REQ_PLAT, 1'b1, 3'b001);
        serveRect(REQ_LOAD, 1'b1, '0);
    endtask

    task automatic test_zeroSize();
        setRect(REQ_BALL, $urandom_range(0, 150), $urandom_range(0, 110), 0, 5, $urandom_range(1, 7));
        reqMask = 3'b010;
        driveInputs();
        serveRect(REQ_BALL, 1'b1, '0);
    endtask

    task automatic test_clipping();
        setRect(REQ_PLAT, 158, 119, 4, 2, 5);
        reqMask = 3'b100;
        driveInputs();
        serveRect(REQ_PLAT, 1'b1, '0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 14; r++) begin
            logic [NR-1:0] add;
            logic [NR-1:0] mid;
            int owner;
            add = NR'($urandom_range(0, 7)) & ~reqMask;
            if ((reqMask | add) == '0) add = NR'(1) << $urandom_range(0, NR - 1);
            for (int i = 0; i < NR; i++) if (add[i]) randomRect(i);
            reqMask = reqMask | add;
            driveInputs();
            owner = pickWinner(reqMask);
            mid = NR'($urandom_range(0, 7)) & ~reqMask;
            for (int i = 0; i < NR; i++) if (mid[i]) randomRect(i);
            serveRect(owner, 1'b1, mid);
        end
        for (int d = 0; d < NR && reqMask != '0; d++) begin
            serveRect(pickWinner(reqMask), 1'b1, '0);
        end
    endtask

    task automatic test_midDrawReset();
        logic [30:0] got;
        test_reset();
        setRect(REQ_LOAD, $urandom_range(0, 150), $urandom_range(0, 110), 4, 4, $urandom_range(1, 7));
        reqMask = 3'b001;
        driveInputs();
        @(negedge clk);
        vectors++;
        if (busIf.gnt !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL abort_gnt: got %b expected %b", busIf.gnt, 3'b001);
        end
        reqMask = '0;
        driveInputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got = {busIf.gnt, busIf.done, busIf.busy, busIf.plot, busIf.vga_x, busIf.vga_y, busIf.vga_colour};
        vectors++;
        if (got !== 31'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got %h expected %h", got, 31'd0);
        end
        reset       = 1'b0;
        modelRrLast = NR - 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if ({busIf.done, busIf.busy} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL abort_no_done[%0d] {done,busy}: got %b expected %b", i, {busIf.done, busIf.busy}, 4'b0000);
            end
        end
        setRect(REQ_PLAT, $urandom_range(0, 150), $urandom_range(0, 110), 2, 3, $urandom_range(0, 7));
        reqMask = 3'b100;
        driveInputs();
        serveRect(pickWinner(reqMask), 1'b1, '0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NR; i++) setRect(i, 0, 0, 0, 0, 0);
        driveInputs();
        test_reset();
        test_singleRect();
        test_roundRobin();
        test_simultaneous();
        test_zeroSize();
        test_clipping();
        test_random();
        test_midDrawReset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
